// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Framed byte-stream loader that fills instruction memory and
//            holds the CPU while a load session is in progress.
// Revision : 1.0
// ============================================================================
module prog_loader #(
  parameter int INSTR_BYTES    = 3,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     wr_enable,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [8*INSTR_BYTES-1:0] wr_data,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int c_WORD_W = 8 * INSTR_BYTES;
  localparam int c_IDX_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(INSTR_BYTES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LEN   = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_CHECK = 3'd3;
  localparam logic [2:0] c_ST_OK    = 3'd4;
  localparam logic [2:0] c_ST_FAIL  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [8:0]          length_q, length_d;
  logic [8:0]          words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [c_IDX_W-1:0]  idx_q, idx_d;
  logic [c_WORD_W-9:0] word_q, word_d;
  logic [7:0]          chk_q, chk_d;
  logic [c_TO_W-1:0]   to_q, to_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [c_WORD_W-1:0] wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hold_q, hold_d;

  logic                w_active;
  logic                w_accept;
  logic [c_WORD_W-1:0] w_shift;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_ST_IDLE;
      length_q  <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      chk_q     <= '0;
      to_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      to_q      <= to_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hold_q    <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    words_d   = words_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    word_d    = word_q;
    chk_d     = chk_q;
    to_d      = to_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    error_d   = error_q;
    hold_d    = hold_q;
    w_accept  = w_active && in_valid;
    w_shift   = {word_q, in_data};

    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          state_d = c_ST_LEN;
          addr_d  = '0;
          words_d = '0;
          idx_d   = '0;
          chk_d   = '0;
          to_d    = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
        end
      end
      c_ST_LEN: begin
        if (w_accept) begin
          length_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          chk_d    = chk_q ^ in_data;
          state_d  = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_accept) begin
          word_d = w_shift[c_WORD_W-9:0];
          chk_d  = chk_q ^ in_data;
          if (idx_q == c_LAST_IDX) begin
            idx_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = w_shift;
            words_d   = words_q + 9'd1;
            // The final word leaves addr in place so it never runs past the image.
            if (words_q + 9'd1 == length_q) begin
              state_d = c_ST_CHECK;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      c_ST_CHECK: begin
        if (w_accept) begin
          state_d = (in_data == chk_q) ? c_ST_OK : c_ST_FAIL;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase

    if (w_active) begin
      if (w_accept) begin
        to_d = '0;
      end else if (to_q == c_TO_LAST) begin
        to_d    = '0;
        state_d = c_ST_FAIL;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    // cpu_hold is only released by a successful session.
    if (state_d == c_ST_OK) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == c_ST_FAIL) begin
      error_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    w_active  = (state_q == c_ST_LEN) || (state_q == c_ST_DATA) ||
                (state_q == c_ST_CHECK);
    in_ready  = w_active;
    busy      = w_active;
    wr_enable = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    cpu_hold  = hold_q;
    done      = done_q;
    error     = error_q;
  end

endmodule
`default_nettype wire
